// File: rtl/mm_pkg.sv
// ---------------------------------------------------------------------------
// mm_pkg
// Shared types and constants for the folded GF(2^n) multiplier front end.
//   alg_mode_e   : array algorithm select (0..6 legal, 7 illegal)
//   fold_state_e : sequencer states of mm_fold_ctrl
//   N, BH, LANES, LANE_W : operand width, folded B width, lane geometry
// ---------------------------------------------------------------------------
package mm_pkg;

  localparam int N      = 128;
  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int BH     = N / 2;

  typedef enum logic [2:0] {
    MODE_SPN8    = 3'd0,
    MODE_SPN16   = 3'd1,
    MODE_SPN32   = 3'd2,
    MODE_WARX    = 3'd3,
    MODE_SPN24   = 3'd4,
    MODE_YOROI16 = 3'd5,
    MODE_YOROI32 = 3'd6,
    MODE_ILLEGAL = 3'd7
  } alg_mode_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    WB   = 3'd3,
    ERR  = 3'd4
  } fold_state_e;

endpackage

// File: rtl/mm_b_fold.sv
// ---------------------------------------------------------------------------
// mm_b_fold
// Combinational lane-nibble selector feeding the folded array's B bus.
// Each 8-bit lane of b_q contributes one nibble per pass: the low nibble on
// pass 0 and the high nibble on pass 1. With en low the bus is forced to 0.
// Ports:
//   b_q  [N-1:0]  in   registered full-width operand B
//   en            in   1 while a pass is being driven
//   pass          in   0 = low nibbles, 1 = high nibbles
//   mm_b [BH-1:0] out  folded B bus to the array
// ---------------------------------------------------------------------------
module mm_b_fold #(
  parameter int N  = 128,
  parameter int BH = 64
) (
  input  logic [N-1:0]  b_q,
  input  logic          en,
  input  logic          pass,
  output logic [BH-1:0] mm_b
);

  genvar gi;
  generate
    for (gi = 0; gi < BH / 4; gi++) begin : g_lane
      assign mm_b[4*gi+3:4*gi] = !en  ? 4'h0 :
                                 pass ? b_q[8*gi+7:8*gi+4] :
                                        b_q[8*gi+3:8*gi];
    end
  endgenerate

endmodule

// File: rtl/mm_fold_ctrl.sv
// ---------------------------------------------------------------------------
// mm_fold_ctrl
// Sequencer upstream of the folded multiplier array. Accepts one operand
// pair, drives two folded passes (low B nibbles, then high B nibbles with
// feedback via sel_op), captures the array's registered product and offers
// it downstream. Mode 7 skips the array and returns an error result.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           operand handshake; in_mode, in_a, in_b
//   mm_alg_mode, mm_sel_op,
//   mm_a, mm_b                  drive to the array
//   mm_c                        registered product from the array
//   out_valid/out_ready         result handshake; out_c, out_err
//   perf_ops, perf_stall        only when MM_FOLD_PERF_EN is defined:
//                               completed transactions / stalled result cycles
// ---------------------------------------------------------------------------
module mm_fold_ctrl #(
  parameter int N  = mm_pkg::N,
  parameter int BH = mm_pkg::BH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_mode,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic [2:0]    mm_alg_mode,
  output logic          mm_sel_op,
  output logic [N-1:0]  mm_a,
  output logic [BH-1:0] mm_b,
  input  logic [N-1:0]  mm_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_c,
`ifdef MM_FOLD_PERF_EN
  output logic [31:0]   perf_ops,
  output logic [31:0]   perf_stall,
`endif
  output logic          out_err
);

  import mm_pkg::*;

  fold_state_e   state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [2:0]    mode_q, mode_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_c_q, out_c_d;
  logic          out_err_q, out_err_d;
  logic          accept;

  // Only one op in flight; the result slot must be free (or freeing now).
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    out_err_d   = out_err_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_a;
          b_d     = in_b;
          mode_d  = in_mode;
          state_d = (in_mode == MODE_ILLEGAL) ? ERR : P0;
        end
      end
      P0: state_d = P1;
      P1: state_d = WB;
      WB: begin
        out_c_d     = mm_c;
        out_err_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        out_c_d     = '0;
        out_err_d   = 1'b1;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      out_err_q   <= out_err_d;
    end
  end

  // Array drive: sel_op=1 on pass 1 makes the array fold its held pass-0
  // result back in; P0 uses sel_op=0, which also flushes any stale content.
  assign mm_a        = a_q;
  assign mm_alg_mode = mode_q;
  assign mm_sel_op   = (state_q == P1);

  mm_b_fold #(.N(N), .BH(BH)) u_b_fold (
    .b_q  (b_q),
    .en   ((state_q == P0) || (state_q == P1)),
    .pass (state_q == P1),
    .mm_b (mm_b)
  );

  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign out_err   = out_err_q;

`ifdef MM_FOLD_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    // WB and ERR each complete exactly one transaction.
    if ((state_q == WB) || (state_q == ERR)) begin
      perf_ops_d = perf_ops_q + 32'd1;
    end
    if (out_valid_q && !out_ready) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mm_fold_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mm_fold_ctrl
// Directed bench for mm_fold_ctrl. The multiplier array is replaced by a
// simple registered stand-in whose result is easy to derive by hand:
//   sel_op = 0 : c <= {64'h0, mm_b} ^ mm_a
//   sel_op = 1 : c <= c ^ {mm_b, 64'h0}
// so a completed op yields A ^ {high-nibble fold, low-nibble fold}, which
// exposes lane mapping, nibble order and pass timing.
// ---------------------------------------------------------------------------
module tb_mm_fold_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_mode;
  logic [127:0]  in_a;
  logic [127:0]  in_b;
  logic [2:0]    mm_alg_mode;
  logic          mm_sel_op;
  logic [127:0]  mm_a;
  logic [63:0]   mm_b;
  logic [127:0]  mm_c;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_c;
  logic          out_err;
`ifdef MM_FOLD_PERF_EN
  logic [31:0]   perf_ops;
  logic [31:0]   perf_stall;
`endif

  int tests = 0;
  int fails = 0;
  int ops_exp = 0;

  always #5 clk = ~clk;

  mm_fold_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_mode     (in_mode),
    .in_a        (in_a),
    .in_b        (in_b),
    .mm_alg_mode (mm_alg_mode),
    .mm_sel_op   (mm_sel_op),
    .mm_a        (mm_a),
    .mm_b        (mm_b),
    .mm_c        (mm_c),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_c       (out_c),
`ifdef MM_FOLD_PERF_EN
    .perf_ops    (perf_ops),
    .perf_stall  (perf_stall),
`endif
    .out_err     (out_err)
  );

  // Array stand-in with its own output register.
  logic [127:0] arr_c_q = '0;
  always @(posedge clk) begin
    if (mm_sel_op) arr_c_q <= arr_c_q ^ {mm_b, 64'h0};
    else           arr_c_q <= {64'h0, mm_b} ^ mm_a;
  end
  assign mm_c = arr_c_q;

  localparam logic [127:0] A01   = 128'h01010101010101010101010101010101;
  localparam logic [127:0] B01   = 128'h01010101010101010101010101010101;
  localparam logic [127:0] B80   = 128'h80808080808080808080808080808080;
  localparam logic [127:0] BLANE = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] AZ    = 128'hdeadbeef00000000cafef00d12345678;
  // Hand-derived stand-in results.
  localparam logic [127:0] EXP1  = 128'h0101010101010101_1010101010101010;
  localparam logic [127:0] EXP2  = 128'h8989898989898989_0101010101010101;
  localparam logic [127:0] EXPL  = 128'h0123456789abcdef_fedcba9876543210;

  // Called just after a negedge; returns at the negedge of cycle accept+1.
  task automatic issue(input logic [127:0] a, input logic [127:0] b, input logic [2:0] m);
    int n;
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    // Garbage on un-accepted inputs must be ignored.
    in_valid = 1'b0;
    in_a = '1; in_b = '1; in_mode = 3'd5;
  endtask

  // Started at accept+1; lat counts cycles from accept to out_valid.
  task automatic wait_out(output int lat, output bit sel_seen);
    lat = 1;
    sel_seen = mm_sel_op;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
      sel_seen |= mm_sel_op;
    end
    if (out_valid) ops_exp++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mode = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: in_ready=%0b out_valid=%0b out_err=%0b required 1 0 0", in_ready, out_valid, out_err);
    end
    tests++;
    if (out_c !== 128'h0 || mm_a !== 128'h0 || mm_b !== 64'h0 || mm_sel_op !== 1'b0 || mm_alg_mode !== 3'd0) begin
      fails++;
      $display("FAIL reset_data: out_c=%h mm_a=%h mm_b=%h sel=%0b mode=%0d required all 0", out_c, mm_a, mm_b, mm_sel_op, mm_alg_mode);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    int lat; bit sel;
    issue(A01, B01, 3'd0);
    wait_out(lat, sel);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL basic_latency: got %0d required 4", lat); end
    tests++;
    if (out_c !== EXP1 || out_err !== 1'b0) begin
      fails++; $display("FAIL basic_result: out_c=%h err=%0b required %h 0", out_c, out_err, EXP1);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_consume: out_valid=%0b required 0", out_valid); end
    $display("[TB] basic spn8 01x01 out_c=%h lat=%0d", out_c, lat);
  endtask

  task automatic test_nibble_order();
    int lat; bit sel;
    issue(A01, B80, 3'd0);
    wait_out(lat, sel);
    tests++;
    if (out_c !== EXP2 || lat !== 4) begin
      fails++; $display("FAIL nibble_order: out_c=%h lat=%0d required %h 4", out_c, lat, EXP2);
    end
    $display("[TB] nibble order spn8 01x80 out_c=%h", out_c);
    @(negedge clk);
  endtask

  task automatic test_lanes();
    issue(128'h0, BLANE, 3'd1);
    tests++;
    if (mm_b !== 64'hfedcba9876543210 || mm_sel_op !== 1'b0 || mm_alg_mode !== 3'd1) begin
      fails++; $display("FAIL lanes_p0: mm_b=%h sel=%0b mode=%0d required fedcba9876543210 0 1", mm_b, mm_sel_op, mm_alg_mode);
    end
    @(negedge clk);
    tests++;
    if (mm_b !== 64'h0123456789abcdef || mm_sel_op !== 1'b1) begin
      fails++; $display("FAIL lanes_p1: mm_b=%h sel=%0b required 0123456789abcdef 1", mm_b, mm_sel_op);
    end
    @(negedge clk);
    tests++;
    if (mm_b !== 64'h0 || mm_sel_op !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL lanes_wb: mm_b=%h sel=%0b out_valid=%0b required 0 0 0", mm_b, mm_sel_op, out_valid);
    end
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b1 || out_c !== EXPL) begin
      fails++; $display("FAIL lanes_result: out_valid=%0b out_c=%h required 1 %h", out_valid, out_c, EXPL);
    end
    if (out_valid) ops_exp++;
    $display("[TB] lane map spn16 out_c=%h", out_c);
    @(negedge clk);
  endtask

  task automatic test_zero();
    int lat; bit sel;
    issue(AZ, 128'h0, 3'd2);
    tests++;
    if (mm_sel_op !== 1'b0 || mm_a !== AZ || mm_b !== 64'h0) begin
      fails++; $display("FAIL zero_p0: sel=%0b mm_a=%h mm_b=%h required 0 %h 0", mm_sel_op, mm_a, mm_b, AZ);
    end
    wait_out(lat, sel);
    tests++;
    if (out_c !== AZ || lat !== 4 || !sel) begin
      fails++; $display("FAIL zero_result: out_c=%h lat=%0d sel_seen=%0b required %h 4 1", out_c, lat, sel, AZ);
    end
    $display("[TB] zero B spn32 out_c=%h", out_c);
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int lat; bit sel;
    issue(A01, B01, 3'd7);
    wait_out(lat, sel);
    tests++;
    if (lat !== 2 || sel !== 1'b0) begin
      fails++; $display("FAIL illegal_timing: lat=%0d sel_seen=%0b required 2 0", lat, sel);
    end
    tests++;
    if (out_c !== 128'h0 || out_err !== 1'b1) begin
      fails++; $display("FAIL illegal_result: out_c=%h err=%0b required 0 1", out_c, out_err);
    end
    $display("[TB] illegal mode out_err=%0b lat=%0d", out_err, lat);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit sel;
    issue(A01, B01, 3'd7);
    wait_out(lat, sel);
    // Next op accepted in the same cycle the error result is taken.
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      fails++; $display("FAIL b2b_ready: in_ready=%0b out_valid=%0b required 1 1", in_ready, out_valid);
    end
    issue(A01, B80, 3'd0);
    wait_out(lat, sel);
    tests++;
    if (out_c !== EXP2 || out_err !== 1'b0 || lat !== 4) begin
      fails++; $display("FAIL b2b_result: out_c=%h err=%0b lat=%0d required %h 0 4", out_c, out_err, lat, EXP2);
    end
    $display("[TB] back-to-back err then spn8 out_c=%h", out_c);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat; bit sel; int bad;
    out_ready = 1'b0;
    issue(A01, B01, 3'd0);
    wait_out(lat, sel);
    in_a = A01; in_b = B80; in_mode = 3'd0; in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_c !== EXP1) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL bp_hold: %0d bad cycles, required in_ready=0 out_c=%h held", bad, EXP1);
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: in_ready=%0b required 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
`ifdef MM_FOLD_PERF_EN
    tests++;
    if (perf_stall !== 32'd5) begin fails++; $display("FAIL perf_stall: got %0d required 5", perf_stall); end
`endif
    wait_out(lat, sel);
    tests++;
    if (out_c !== EXP2 || lat !== 4) begin
      fails++; $display("FAIL bp_next: out_c=%h lat=%0d required %h 4", out_c, lat, EXP2);
    end
    $display("[TB] backpressure 5 cycles then accept out_c=%h", out_c);
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int lat; bit sel;
`ifdef MM_FOLD_PERF_EN
    tests++;
    if (perf_ops !== 32'(ops_exp)) begin fails++; $display("FAIL perf_ops: got %0d required %0d", perf_ops, ops_exp); end
`endif
    issue(A01, B80, 3'd0);
    @(negedge clk);
    tests++;
    if (mm_sel_op !== 1'b1) begin fails++; $display("FAIL midop_in_p1: sel=%0b required 1", mm_sel_op); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midop_reset: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    end
`ifdef MM_FOLD_PERF_EN
    tests++;
    if (perf_ops !== 32'd0 || perf_stall !== 32'd0) begin
      fails++; $display("FAIL perf_reset: ops=%0d stall=%0d required 0 0", perf_ops, perf_stall);
    end
`endif
    @(negedge clk);
    issue(A01, B01, 3'd0);
    wait_out(lat, sel);
    tests++;
    if (out_c !== EXP1 || lat !== 4) begin
      fails++; $display("FAIL midop_after: out_c=%h lat=%0d required %h 4", out_c, lat, EXP1);
    end
    $display("[TB] reset mid-op then spn8 out_c=%h", out_c);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nibble_order();
    test_lanes();
    test_zero();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
